spm_portb_arb: RTL and testbench

Port-B arbiter and sequencer for the banked scratchpad memory (SPM). Shares the SPM's single port B between encoder write traffic and AXI slave accesses through req/gnt handshakes. Grants both in the same cycle when they target different banks; on a same-bank conflict it applies encoder priority bounded by an AXI anti-starvation counter. All SPM-side controls are registered, and the block tracks the SPM read pipeline to produce an aligned AXI read-valid strobe.

---
 rtl/spm_portb_arb.sv | 140 ++++++++++++++
 tb/tb_spm_portb_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_portb_arb.sv
// Port-B arbiter for the banked scratchpad: shares SPM port B between encoder writes and AXI
// accesses, grants both when banks differ, and aligns an AXI read-valid strobe to the SPM pipeline.
module spm_portb_arb #(
   parameter int URAM_ADDR_WIDTH = 12,
   parameter int BANK_NUM        = 4,
   parameter int NUM_LANE        = 128,
   parameter int DATA_WIDTH      = 64,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 512,
   parameter int NB_PIPE         = 3,
   parameter int MAX_WAIT        = 4,
   localparam int BANK_BITS      = $clog2(BANK_NUM),
   localparam int SPM_ADDR_WIDTH = BANK_BITS + URAM_ADDR_WIDTH,
   localparam int COL_BITS       = $clog2(NUM_LANE * DATA_WIDTH / AXI_DATA_WIDTH),
   localparam int ROW_WIDTH      = NUM_LANE * DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_enc_req,
   input  logic [SPM_ADDR_WIDTH-1:0] i_enc_addr,
   input  logic [ROW_WIDTH-1:0]      i_enc_data,
   output logic                      o_enc_gnt,
   input  logic                      i_axi_req,
   input  logic                      i_axi_wr,
   input  logic [AXI_ADDR_WIDTH-1:0] i_axi_addr,
   input  logic [AXI_DATA_WIDTH-1:0] i_axi_wdata,
   output logic                      o_axi_gnt,
   output logic                      o_axi_rvalid,
   output logic                      o_spm_encode_wr_en,
   output logic [SPM_ADDR_WIDTH-1:0] o_spm_encode_addr,
   output logic [ROW_WIDTH-1:0]      o_spm_encode_data,
   output logic                      o_spm_axi_en,
   output logic                      o_spm_axi_wr_en,
   output logic [AXI_ADDR_WIDTH-1:0] o_spm_axi_addr,
   output logic [AXI_DATA_WIDTH-1:0] o_spm_axi_wr_data,
   output logic [15:0]               o_conflict_cnt
);

   localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

   typedef enum logic {ENC_PRI = 1'b0, AXI_PRI = 1'b1} pri_state_t;

   pri_state_t                r_state;
   logic [WAIT_W-1:0]         r_wait;
   logic [15:0]               r_conflict_cnt;
   logic [NB_PIPE:0]          r_rd_pipe;
   logic                      r_enc_wr_en;
   logic [SPM_ADDR_WIDTH-1:0] r_enc_addr;
   logic [ROW_WIDTH-1:0]      r_enc_data;
   logic                      r_axi_en;
   logic                      r_axi_wr_en;
   logic [AXI_ADDR_WIDTH-1:0] r_axi_addr;
   logic [AXI_DATA_WIDTH-1:0] r_axi_wdata;

   logic [BANK_BITS-1:0] w_enc_bank;
   logic [BANK_BITS-1:0] w_axi_bank;
   logic                 w_conflict;
   logic                 w_enc_gnt;
   logic                 w_axi_gnt;
   logic [WAIT_W-1:0]    w_wait_inc;

   assign w_enc_bank = i_enc_addr[URAM_ADDR_WIDTH +: BANK_BITS];
   assign w_axi_bank = i_axi_addr[COL_BITS + URAM_ADDR_WIDTH +: BANK_BITS];
   assign w_conflict = i_enc_req & i_axi_req & (w_enc_bank == w_axi_bank);

   // The loser of a same-bank conflict is whichever side the priority state does not favour.
   assign w_enc_gnt  = i_enc_req & ~(w_conflict & (r_state == AXI_PRI));
   assign w_axi_gnt  = i_axi_req & ~(w_conflict & (r_state == ENC_PRI));
   assign w_wait_inc = r_wait + WAIT_W'(1);

   // Grants are masked while reset is held so every output reads 0 during reset.
   assign o_enc_gnt = w_enc_gnt & ~rst;
   assign o_axi_gnt = w_axi_gnt & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ENC_PRI;
         r_wait  <= '0;
      end else if (i_axi_req && !w_axi_gnt) begin
         if (r_wait < WAIT_W'(MAX_WAIT))
            r_wait <= w_wait_inc;
         if ((r_state == ENC_PRI) && (w_wait_inc == WAIT_W'(MAX_WAIT)))
            r_state <= AXI_PRI;
      end else begin
         r_wait  <= '0;
         r_state <= ENC_PRI;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   // Enables pulse for one cycle per grant; address/data hold their last captured value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enc_wr_en <= 1'b0;
         r_enc_addr  <= '0;
         r_enc_data  <= '0;
         r_axi_en    <= 1'b0;
         r_axi_wr_en <= 1'b0;
         r_axi_addr  <= '0;
         r_axi_wdata <= '0;
      end else begin
         r_enc_wr_en <= w_enc_gnt;
         r_axi_en    <= w_axi_gnt;
         r_axi_wr_en <= w_axi_gnt & i_axi_wr;
         if (w_enc_gnt) begin
            r_enc_addr <= i_enc_addr;
            r_enc_data <= i_enc_data;
         end
         if (w_axi_gnt) begin
            r_axi_addr  <= i_axi_addr;
            r_axi_wdata <= i_axi_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_rd_pipe <= '0;
      else
         r_rd_pipe <= {r_rd_pipe[NB_PIPE-1:0], w_axi_gnt & ~i_axi_wr};
   end

   assign o_axi_rvalid       = r_rd_pipe[NB_PIPE];
   assign o_spm_encode_wr_en = r_enc_wr_en;
   assign o_spm_encode_addr  = r_enc_addr;
   assign o_spm_encode_data  = r_enc_data;
   assign o_spm_axi_en       = r_axi_en;
   assign o_spm_axi_wr_en    = r_axi_wr_en;
   assign o_spm_axi_addr     = r_axi_addr;
   assign o_spm_axi_wr_data  = r_axi_wdata;
   assign o_conflict_cnt     = r_conflict_cnt;

endmodule

// File: tb/tb_spm_portb_arb.sv
// Directed bench for spm_portb_arb: parallel grants, starvation bound, read alignment,
// mid-flight reset and conflict counter saturation.
module tb_spm_portb_arb;

   localparam int SAW = 14;
   localparam int EDW = 128 * 64;
   localparam int AAW = 32;
   localparam int ADW = 512;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           i_enc_req = 1'b0;
   logic [SAW-1:0] i_enc_addr = '0;
   logic [EDW-1:0] i_enc_data = '0;
   logic           o_enc_gnt;
   logic           i_axi_req = 1'b0;
   logic           i_axi_wr = 1'b0;
   logic [AAW-1:0] i_axi_addr = '0;
   logic [ADW-1:0] i_axi_wdata = '0;
   logic           o_axi_gnt;
   logic           o_axi_rvalid;
   logic           o_spm_encode_wr_en;
   logic [SAW-1:0] o_spm_encode_addr;
   logic [EDW-1:0] o_spm_encode_data;
   logic           o_spm_axi_en;
   logic           o_spm_axi_wr_en;
   logic [AAW-1:0] o_spm_axi_addr;
   logic [ADW-1:0] o_spm_axi_wr_data;
   logic [15:0]    o_conflict_cnt;

   int checks = 0;
   int failures = 0;

   logic [EDW-1:0] pat_a;
   logic [EDW-1:0] pat_b;
   logic [ADW-1:0] pat_c;

   spm_portb_arb dut (
      .clk                (clk),
      .rst                (rst),
      .i_enc_req          (i_enc_req),
      .i_enc_addr         (i_enc_addr),
      .i_enc_data         (i_enc_data),
      .o_enc_gnt          (o_enc_gnt),
      .i_axi_req          (i_axi_req),
      .i_axi_wr           (i_axi_wr),
      .i_axi_addr         (i_axi_addr),
      .i_axi_wdata        (i_axi_wdata),
      .o_axi_gnt          (o_axi_gnt),
      .o_axi_rvalid       (o_axi_rvalid),
      .o_spm_encode_wr_en (o_spm_encode_wr_en),
      .o_spm_encode_addr  (o_spm_encode_addr),
      .o_spm_encode_data  (o_spm_encode_data),
      .o_spm_axi_en       (o_spm_axi_en),
      .o_spm_axi_wr_en    (o_spm_axi_wr_en),
      .o_spm_axi_addr     (o_spm_axi_addr),
      .o_spm_axi_wr_data  (o_spm_axi_wr_data),
      .o_conflict_cnt     (o_conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      i_enc_req = 1'b0;
      i_axi_req = 1'b0;
      i_axi_wr  = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      i_enc_req = 1'b1;
      i_axi_req = 1'b1;
      i_enc_addr = 14'h0001;
      i_axi_addr = 32'h0000_0001;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({o_enc_gnt, o_axi_gnt, o_axi_rvalid, o_spm_encode_wr_en, o_spm_axi_en, o_spm_axi_wr_en} !== 6'b0) begin
         failures++;
         $display("FAIL rst_ctrl: got %b want 000000", {o_enc_gnt, o_axi_gnt, o_axi_rvalid, o_spm_encode_wr_en, o_spm_axi_en, o_spm_axi_wr_en});
      end
      tick();
      checks++;
      if (o_spm_encode_addr !== '0 || o_spm_axi_addr !== '0 || o_spm_encode_data !== '0 || o_spm_axi_wr_data !== '0 || o_conflict_cnt !== 16'd0) begin
         failures++;
         $display("FAIL rst_data: enc_addr=%h axi_addr=%h cnt=%0d want all 0", o_spm_encode_addr, o_spm_axi_addr, o_conflict_cnt);
      end
      checks++;
      if (o_enc_gnt !== 1'b0 || o_axi_gnt !== 1'b0 || o_spm_encode_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL rst_hold: enc_gnt=%b axi_gnt=%b enc_wr_en=%b want 0", o_enc_gnt, o_axi_gnt, o_spm_encode_wr_en);
      end
      idle_inputs();
      rst = 1'b0;
      tick();
      $display("INFO test_reset done");
   endtask

   task automatic test_parallel;
      i_enc_req = 1'b1; i_enc_addr = 14'h0123; i_enc_data = pat_a;
      i_axi_req = 1'b1; i_axi_wr = 1'b0; i_axi_addr = 32'h0002_0035; i_axi_wdata = pat_c;
      #1;
      checks++;
      if (o_enc_gnt !== 1'b1 || o_axi_gnt !== 1'b1) begin
         failures++;
         $display("FAIL par_gnt: enc_gnt=%b axi_gnt=%b want 1 1", o_enc_gnt, o_axi_gnt);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (o_spm_encode_wr_en !== 1'b1 || o_spm_encode_addr !== 14'h0123 || o_spm_encode_data !== pat_a) begin
         failures++;
         $display("FAIL par_enc_out: wr_en=%b addr=%h want 1 0123", o_spm_encode_wr_en, o_spm_encode_addr);
      end
      checks++;
      if (o_spm_axi_en !== 1'b1 || o_spm_axi_wr_en !== 1'b0 || o_spm_axi_addr !== 32'h0002_0035) begin
         failures++;
         $display("FAIL par_axi_out: en=%b wr_en=%b addr=%h want 1 0 00020035", o_spm_axi_en, o_spm_axi_wr_en, o_spm_axi_addr);
      end
      checks++;
      if (o_conflict_cnt !== 16'd0) begin
         failures++;
         $display("FAIL par_cnt: got %0d want 0", o_conflict_cnt);
      end
      for (int k = 1; k <= 6; k++) begin
         checks++;
         if (o_axi_rvalid !== (k == 4)) begin
            failures++;
            $display("FAIL par_rvalid_T+%0d: got %b want %b", k, o_axi_rvalid, (k == 4));
         end
         if (k == 2) begin
            checks++;
            if (o_spm_encode_wr_en !== 1'b0 || o_spm_axi_en !== 1'b0 || o_spm_encode_addr !== 14'h0123) begin
               failures++;
               $display("FAIL par_one_cycle: enc_wr_en=%b axi_en=%b addr=%h want 0 0 0123", o_spm_encode_wr_en, o_spm_axi_en, o_spm_encode_addr);
            end
         end
         tick();
      end
      $display("INFO test_parallel done");
   endtask

   task automatic test_starvation;
      do_reset();
      i_enc_req = 1'b1; i_enc_addr = 14'h1055; i_enc_data = pat_b;
      i_axi_req = 1'b1; i_axi_wr = 1'b1; i_axi_addr = 32'h0001_0007; i_axi_wdata = pat_c;
      for (int i = 1; i <= 5; i++) begin
         #1;
         checks++;
         if (o_enc_gnt !== (i != 5) || o_axi_gnt !== (i == 5)) begin
            failures++;
            $display("FAIL starve_cyc%0d: enc_gnt=%b axi_gnt=%b want %b %b", i, o_enc_gnt, o_axi_gnt, (i != 5), (i == 5));
         end
         tick();
      end
      #1;
      checks++;
      if (o_spm_axi_en !== 1'b1 || o_spm_axi_wr_en !== 1'b1 || o_spm_axi_wr_data !== pat_c || o_spm_encode_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL starve_out: axi_en=%b axi_wr_en=%b enc_wr_en=%b want 1 1 0", o_spm_axi_en, o_spm_axi_wr_en, o_spm_encode_wr_en);
      end
      checks++;
      if (o_conflict_cnt !== 16'd5) begin
         failures++;
         $display("FAIL starve_cnt: got %0d want 5", o_conflict_cnt);
      end
      checks++;
      if (o_enc_gnt !== 1'b1 || o_axi_gnt !== 1'b0) begin
         failures++;
         $display("FAIL starve_back_enc_pri: enc_gnt=%b axi_gnt=%b want 1 0", o_enc_gnt, o_axi_gnt);
      end
      tick();
      idle_inputs();
      for (int k = 7; k <= 10; k++) begin
         checks++;
         if (o_axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL starve_wr_rvalid_c%0d: got %b want 0", k, o_axi_rvalid);
         end
         tick();
      end
      $display("INFO test_starvation done");
   endtask

   task automatic test_wait_restart;
      do_reset();
      i_enc_req = 1'b1; i_enc_addr = 14'h3001;
      i_axi_req = 1'b1; i_axi_wr = 1'b0; i_axi_addr = 32'h0003_0000;
      for (int i = 1; i <= 8; i++) begin
         i_axi_req = (i != 3);
         #1;
         checks++;
         if (o_axi_gnt !== (i == 8) || o_enc_gnt !== (i != 8)) begin
            failures++;
            $display("FAIL restart_cyc%0d: enc_gnt=%b axi_gnt=%b want %b %b", i, o_enc_gnt, o_axi_gnt, (i != 8), (i == 8));
         end
         tick();
      end
      idle_inputs();
      $display("INFO test_wait_restart done");
   endtask

   task automatic test_back_to_back;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         i_axi_req = 1'b1; i_axi_wr = 1'b0; i_axi_addr = 32'h0000_0100 + i;
         #1;
         checks++;
         if (o_axi_gnt !== 1'b1 || o_axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gnt%0d: gnt=%b rvalid=%b want 1 0", i, o_axi_gnt, o_axi_rvalid);
         end
         tick();
      end
      idle_inputs();
      for (int k = 3; k <= 8; k++) begin
         #1;
         if (k == 3) begin
            checks++;
            if (o_spm_axi_en !== 1'b1 || o_spm_axi_addr !== 32'h0000_0102) begin
               failures++;
               $display("FAIL b2b_addr: en=%b addr=%h want 1 00000102", o_spm_axi_en, o_spm_axi_addr);
            end
         end
         checks++;
         if (o_axi_rvalid !== (k >= 4 && k <= 6)) begin
            failures++;
            $display("FAIL b2b_rvalid_T+%0d: got %b want %b", k, o_axi_rvalid, (k >= 4 && k <= 6));
         end
         tick();
      end
      $display("INFO test_back_to_back done");
   endtask

   task automatic test_reset_midflight;
      do_reset();
      i_enc_req = 1'b1; i_enc_addr = 14'h2010;
      i_axi_req = 1'b1; i_axi_wr = 1'b1; i_axi_addr = 32'h0002_0000;
      tick();
      tick();
      i_enc_req = 1'b0;
      i_axi_wr = 1'b0; i_axi_addr = 32'h0000_0200;
      #1;
      checks++;
      if (o_axi_gnt !== 1'b1 || o_conflict_cnt !== 16'd2) begin
         failures++;
         $display("FAIL mid_setup: axi_gnt=%b cnt=%0d want 1 2", o_axi_gnt, o_conflict_cnt);
      end
      tick();
      idle_inputs();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (o_conflict_cnt !== 16'd0 || o_spm_axi_addr !== '0 || o_spm_encode_addr !== '0 || o_axi_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_out: cnt=%0d axi_addr=%h enc_addr=%h rvalid=%b want 0", o_conflict_cnt, o_spm_axi_addr, o_spm_encode_addr, o_axi_rvalid);
      end
      for (int k = 3; k <= 5; k++) begin
         tick();
         checks++;
         if (o_axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rvalid_T+%0d: got %b want 0", k, o_axi_rvalid);
         end
      end
      rst = 1'b0;
      tick();
      i_axi_req = 1'b1; i_axi_wr = 1'b0; i_axi_addr = 32'h0000_0300;
      #1;
      checks++;
      if (o_axi_gnt !== 1'b1) begin
         failures++;
         $display("FAIL mid_regnt: got %b want 1", o_axi_gnt);
      end
      tick();
      idle_inputs();
      for (int k = 1; k <= 5; k++) begin
         #1;
         checks++;
         if (o_axi_rvalid !== (k == 4)) begin
            failures++;
            $display("FAIL mid_new_rvalid_T+%0d: got %b want %b", k, o_axi_rvalid, (k == 4));
         end
         tick();
      end
      $display("INFO test_reset_midflight done");
   endtask

   task automatic test_saturation;
      do_reset();
      i_enc_req = 1'b1; i_enc_addr = 14'h0000;
      i_axi_req = 1'b1; i_axi_wr = 1'b1; i_axi_addr = 32'h0000_0000;
      repeat (65534) tick();
      checks++;
      if (o_conflict_cnt !== 16'hFFFE) begin
         failures++;
         $display("FAIL sat_fffe: got %h want fffe", o_conflict_cnt);
      end
      tick();
      checks++;
      if (o_conflict_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_ffff: got %h want ffff", o_conflict_cnt);
      end
      repeat (4465) tick();
      checks++;
      if (o_conflict_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_hold: got %h want ffff", o_conflict_cnt);
      end
      idle_inputs();
      tick();
      $display("INFO test_saturation done");
   endtask

   initial begin
      pat_a = {128{64'hA5A5_0123_5A5A_4567}};
      pat_b = {128{64'h0F0F_89AB_F0F0_CDEF}};
      pat_c = {8{64'h1357_9BDF_2468_ACE0}};
      test_reset();
      test_parallel();
      test_starvation();
      test_wait_restart();
      test_back_to_back();
      test_reset_midflight();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
